// File: rtl/mem_if_pkg.sv
// Shared definitions for the valid/ready single-port memory interface and its BIST initiator.
package mem_if_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_DEPTH   = 32;
    localparam int unsigned DEF_TIMEOUT = 64;
    localparam int unsigned PAT_W       = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        WR_GAP = 3'd2,
        RD     = 3'd3,
        RD_GAP = 3'd4,
        DONE   = 3'd5
    } state_e;

    // Test pattern: seed + address; callers truncate to their data width.
    function automatic logic [PAT_W-1:0] pattern_data(input logic [PAT_W-1:0] seed,
                                                      input logic [PAT_W-1:0] addr);
        return seed + addr;
    endfunction

endpackage

// File: rtl/mem_ready_watchdog.sv
// Handshake watchdog: counts enabled cycles, flags the cycle in which the count would reach TIMEOUT.
module mem_ready_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_c_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bist_initiator.sv
// Memory BIST initiator: writes seed+addr to every location, reads back, compares, reports status.
module mem_bist_initiator
    import mem_if_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      seed_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  wr_rd_o,
    output logic [WIDTH-1:0]      wdata_o,
    input  logic [WIDTH-1:0]      rdata_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH:0]   err_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic                  timeout_o
);

    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned EW = ADDR_WIDTH + 1;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [EW-1:0]   err_q, err_d;
    logic [AW-1:0]   ferr_q, ferr_d;
    logic            mis_q, mis_d;
    logic            tmo_q, tmo_d;
    logic            valid_q, valid_d;
    logic            wr_q, wr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    logic            in_xfer;
    logic            last_addr;
    logic            wd_en, wd_clr, wd_exp;
    logic [WIDTH-1:0] exp_rdata;

    assign in_xfer   = (state_q == WR) || (state_q == RD);
    assign last_addr = (addr_q == AW'(DEPTH - 1));
    assign exp_rdata = WIDTH'(pattern_data(PAT_W'(seed_q), PAT_W'(addr_q)));

    // Watchdog only runs while a request is outstanding and unanswered.
    assign wd_en  = in_xfer && !ready_i;
    assign wd_clr = !wd_en;

    mem_ready_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (wd_clr),
        .en_i        (wd_en),
        .expired_c_o (wd_exp)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        seed_d  = seed_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        mis_d   = 1'b0;
        tmo_d   = tmo_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = WR;
                    seed_d  = seed_i;
                    addr_d  = '0;
                    err_d   = '0;
                    ferr_d  = '0;
                    tmo_d   = 1'b0;
                end
            end
            WR: begin
                if (wd_exp) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end else if (ready_i) begin
                    state_d = WR_GAP;
                end
            end
            WR_GAP: begin
                if (last_addr) begin
                    addr_d  = '0;
                    state_d = RD;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = WR;
                end
            end
            RD: begin
                if (wd_exp) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end else if (ready_i) begin
                    mis_d   = (rdata_i != exp_rdata);
                    state_d = RD_GAP;
                end
            end
            RD_GAP: begin
                // Registered compare result is folded into the counters during the gap.
                if (mis_q) begin
                    err_d = err_q + EW'(1);
                    if (err_q == '0) begin
                        ferr_d = addr_q;
                    end
                end
                if (last_addr) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = RD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == WR) || (state_d == RD);
        wr_d    = (state_d == WR);
        busy_d  = (state_d == WR) || (state_d == WR_GAP) || (state_d == RD) || (state_d == RD_GAP);
        done_d  = (state_d == DONE);
        pass_d  = done_d && (err_d == '0) && !tmo_d;
        wdata_d = (state_d == WR) ? WIDTH'(pattern_data(PAT_W'(seed_d), PAT_W'(addr_d))) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            seed_q  <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            mis_q   <= 1'b0;
            tmo_q   <= 1'b0;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            seed_q  <= seed_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            mis_q   <= mis_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            wdata_q <= wdata_d;
        end
    end

    assign addr_o           = addr_q;
    assign wr_rd_o          = wr_q;
    assign wdata_o          = wdata_q;
    assign valid_o          = valid_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_cnt_o        = err_q;
    assign first_err_addr_o = ferr_q;
    assign timeout_o        = tmo_q;

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Directed bench for mem_bist_initiator with a behavioural memory (waits, stuck-at, no-ready modes).
module tb_mem_bist_initiator;
    import mem_if_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 32;
    localparam int unsigned AW = 5;

    logic          clk_i;
    logic          rst_i;
    logic          start_i;
    logic [W-1:0]  seed_i;
    logic [AW-1:0] addr_o;
    logic          wr_rd_o;
    logic [W-1:0]  wdata_o;
    logic [W-1:0]  rdata_i;
    logic          valid_o;
    logic          ready_i;
    logic          busy_o;
    logic          done_o;
    logic          pass_o;
    logic [AW:0]   err_cnt_o;
    logic [AW-1:0] first_err_addr_o;
    logic          timeout_o;

    mem_bist_initiator #(
        .WIDTH      (W),
        .DEPTH      (D),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (64)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .seed_i           (seed_i),
        .addr_o           (addr_o),
        .wr_rd_o          (wr_rd_o),
        .wdata_o          (wdata_o),
        .rdata_i          (rdata_i),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .pass_o           (pass_o),
        .err_cnt_o        (err_cnt_o),
        .first_err_addr_o (first_err_addr_o),
        .timeout_o        (timeout_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Behavioural memory
    logic [W-1:0]  mem [D];
    logic          ready_en;
    logic          rand_mode;
    logic          stuck_en;
    logic [AW-1:0] stuck_addr;
    int            wait_left;

    assign ready_i = ready_en && valid_o && (wait_left == 0);

    always_comb begin
        rdata_i = mem[addr_o];
        if (stuck_en && (addr_o == stuck_addr)) rdata_i = '0;
    end

    always @(posedge clk_i) begin
        if (!valid_o) wait_left <= rand_mode ? int'($urandom_range(0, 3)) : 0;
        else if (!ready_i) wait_left <= wait_left - 1;
        if (valid_o && ready_i && wr_rd_o) mem[addr_o] <= wdata_o;
    end

    int n_tests;
    int n_fail;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Per-run monitor results
    int stab_err, gap_err, ord_err, wr_cnt, rd_cnt, err_seen_at, run_cycles;

    task automatic run_check(input logic [31:0] seed, input int budget, input int mid_start);
        logic          pv, pr, pwr;
        logic [AW-1:0] pa;
        logic [W-1:0]  pw;
        int            exp_wr, exp_rd, n;
        pv = 1'b0; pr = 1'b0; pwr = 1'b0; pa = '0; pw = '0;
        exp_wr = 0; exp_rd = 0;
        stab_err = 0; gap_err = 0; ord_err = 0; wr_cnt = 0; rd_cnt = 0; err_seen_at = -1;
        @(negedge clk_i);
        seed_i  = seed;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        seed_i  = 32'h0BAD_0BAD;
        n = 0;
        while (!done_o && n < budget) begin
            if (pv && !pr && (!valid_o || addr_o != pa || wdata_o != pw || wr_rd_o != pwr))
                stab_err++;
            if (pv && pr && valid_o) gap_err++;
            if (valid_o && !wr_rd_o && wdata_o != '0) ord_err++;
            if (valid_o && ready_i) begin
                if (wr_rd_o) begin
                    if (int'(addr_o) != exp_wr ||
                        wdata_o != W'(pattern_data(64'(seed), 64'(addr_o)))) ord_err++;
                    exp_wr++;
                    wr_cnt++;
                end else begin
                    if (int'(addr_o) != exp_rd || wr_cnt != int'(D)) ord_err++;
                    exp_rd++;
                    rd_cnt++;
                end
            end
            if (err_seen_at < 0 && err_cnt_o != '0) err_seen_at = n;
            pv = valid_o; pr = ready_i; pwr = wr_rd_o; pa = addr_o; pw = wdata_o;
            if (n == mid_start) begin
                start_i = 1'b1;
                seed_i  = 32'h5555_5555;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            n++;
        end
        start_i    = 1'b0;
        run_cycles = n;
        chk_eq("run_reached_done", 64'(done_o), 64'd1);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_i      = 1'b0;
        start_i    = 1'b0;
        seed_i     = '0;
        ready_en   = 1'b1;
        rand_mode  = 1'b0;
        stuck_en   = 1'b0;
        stuck_addr = 5'h15;
        for (int i = 0; i < int'(D); i++) mem[i] = '0;
        repeat (2) @(negedge clk_i);

        chk_eq("rst_valid",  64'(valid_o), 64'd0);
        chk_eq("rst_busy",   64'(busy_o), 64'd0);
        chk_eq("rst_flags",  64'({done_o, pass_o, timeout_o, wr_rd_o}), 64'd0);
        chk_eq("rst_errs",   64'({err_cnt_o, first_err_addr_o}), 64'd0);
        rst_i = 1'b1;

        // Zero-wait full run from IDLE
        run_check(32'h1000_0000, 400, -1);
        chk_eq("zw_cycles",  64'(run_cycles), 64'd128);
        chk_eq("zw_pass",    64'(pass_o), 64'd1);
        chk_eq("zw_err_cnt", 64'(err_cnt_o), 64'd0);
        chk_eq("zw_tmo",     64'(timeout_o), 64'd0);
        chk_eq("zw_busy",    64'(busy_o), 64'd0);
        chk_eq("zw_mem0",    64'(mem[0]), 64'h1000_0000);
        chk_eq("zw_mem31",   64'(mem[31]), 64'h1000_001F);
        chk_eq("zw_order",   64'(ord_err), 64'd0);
        chk_eq("zw_counts",  64'({wr_cnt[15:0], rd_cnt[15:0]}), {32'd0, 16'd32, 16'd32});

        // Stuck-at-0 on read of 0x15, restarted straight from DONE
        stuck_en = 1'b1;
        run_check(32'hA5A5_0000, 400, -1);
        chk_eq("sa_err_cnt",  64'(err_cnt_o), 64'd1);
        chk_eq("sa_first",    64'(first_err_addr_o), 64'h15);
        chk_eq("sa_pass",     64'(pass_o), 64'd0);
        chk_eq("sa_done",     64'(done_o), 64'd1);
        chk_eq("sa_err_time", 64'(err_seen_at), 64'd108);
        chk_eq("sa_mem21",    64'(mem[21]), 64'hA5A5_0015);
        stuck_en = 1'b0;

        // Random 0-3 wait states, pattern wraps past 2^32
        rand_mode = 1'b1;
        run_check(32'hFFFF_FFF0, 2000, -1);
        chk_eq("rw_pass",   64'(pass_o), 64'd1);
        chk_eq("rw_stable", 64'(stab_err), 64'd0);
        chk_eq("rw_gap",    64'(gap_err), 64'd0);
        chk_eq("rw_order",  64'(ord_err), 64'd0);
        chk_eq("rw_mem0",   64'(mem[0]), 64'hFFFF_FFF0);
        chk_eq("rw_mem31",  64'(mem[31]), 64'h0000_000F);
        chk_eq("rw_counts", 64'({wr_cnt[15:0], rd_cnt[15:0]}), {32'd0, 16'd32, 16'd32});
        rand_mode = 1'b0;

        // ready_i never asserted
        ready_en = 1'b0;
        run_check(32'h1234_5678, 400, -1);
        chk_eq("to_cycles", 64'(run_cycles), 64'd64);
        chk_eq("to_flag",   64'(timeout_o), 64'd1);
        chk_eq("to_valid",  64'(valid_o), 64'd0);
        chk_eq("to_pass",   64'(pass_o), 64'd0);
        chk_eq("to_addr",   64'(addr_o), 64'd0);
        chk_eq("to_stable", 64'(stab_err), 64'd0);
        ready_en = 1'b1;

        // Reset in the 10th cycle of a run
        @(negedge clk_i);
        seed_i  = 32'h0000_0001;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk_eq("mr_valid", 64'(valid_o), 64'd0);
        chk_eq("mr_busy",  64'(busy_o), 64'd0);
        chk_eq("mr_stat",  64'({done_o, pass_o, timeout_o, err_cnt_o, first_err_addr_o}), 64'd0);
        rst_i = 1'b1;
        run_check(32'h7000_0000, 400, -1);
        chk_eq("mr_cycles", 64'(run_cycles), 64'd128);
        chk_eq("mr_pass",   64'(pass_o), 64'd1);

        // Start pulsed mid-run must be ignored
        run_check(32'h0000_0100, 400, 20);
        chk_eq("ms_cycles", 64'(run_cycles), 64'd128);
        chk_eq("ms_pass",   64'(pass_o), 64'd1);
        chk_eq("ms_order",  64'(ord_err), 64'd0);
        chk_eq("ms_counts", 64'({wr_cnt[15:0], rd_cnt[15:0]}), {32'd0, 16'd32, 16'd32});
        chk_eq("ms_mem5",   64'(mem[5]), 64'h0000_0105);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
